pb_debounce_pulse: RTL and testbench

PB_DEBOUNCE_PULSE -- requirements
Module: pb_debounce_pulse

---
 rtl/pb_debounce_pulse.sv | 137 +++++++++++++
 tb/tb_pb_debounce_pulse.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_pulse.sv
// pb_debounce_pulse
// Pushbutton conditioner. The raw button goes through a two-flop synchronizer,
// is debounced by a four-state FSM, and produces a debounced level plus a
// single-cycle strobe for each accepted press. An optional auto-repeat adds
// further strobes while the button is held.
module pb_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic PB_raw,
  output logic PB_pulse,
  output logic PB_level
);

  // Debounce counter counts 0 .. DEBOUNCE_CYCLES-1, so it must hold DEBOUNCE_CYCLES.
  localparam int DB_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_MAX  = {DB_W{1'b1}};

  // Repeat counter covers the longer of the initial delay and the period.
  localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int R_W   = (R_MAX < 1) ? 1 : $clog2(R_MAX + 1);
  localparam logic [R_W-1:0] R_MAXV     = {R_W{1'b1}};
  localparam logic [R_W-1:0] R_DLY_LAST = R_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
  localparam logic [R_W-1:0] R_PER_LAST = R_W'((REPEAT_PERIOD > 0) ? (REPEAT_PERIOD - 1) : 0);
  localparam bit RPT_EN = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_pbSync;
  logic [DB_W-1:0] r_dbCnt;
  logic [R_W-1:0]  r_rptCnt;
  logic            r_repeating;
  logic            r_pulse;
  logic            r_level;
  logic [R_W-1:0]  w_rptLast;
  logic            w_rptHit;

  // Two-flop synchronizer; r_pbSync is the only view of the button the FSM uses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_pbSync <= 1'b0;
    end else begin
      r_sync1  <= PB_raw;
      r_pbSync <= r_sync1;
    end
  end

  // The first repeat waits the full delay, later ones wait one period.
  always_comb begin
    w_rptLast = r_repeating ? R_PER_LAST : R_DLY_LAST;
    w_rptHit  = RPT_EN && (r_rptCnt == w_rptLast);
  end

  // Debounce FSM with both counters and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dbCnt     <= '0;
      r_rptCnt    <= '0;
      r_repeating <= 1'b0;
      r_pulse     <= 1'b0;
      r_level     <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          r_level <= 1'b0;
          if (r_pbSync) begin
            r_state <= PRESS_CHK;
            r_dbCnt <= '0;
          end
        end

        PRESS_CHK: begin
          if (!r_pbSync) begin
            r_state <= IDLE;
          end else if (r_dbCnt == DB_LAST) begin
            r_state     <= HELD;
            r_pulse     <= 1'b1;
            r_level     <= 1'b1;
            r_rptCnt    <= '0;
            r_repeating <= 1'b0;
          end else if (r_dbCnt != DB_MAX) begin
            r_dbCnt <= r_dbCnt + DB_W'(1);
          end
        end

        HELD: begin
          if (!r_pbSync) begin
            r_state <= RELEASE_CHK;
            r_dbCnt <= '0;
          end else if (w_rptHit) begin
            r_pulse     <= 1'b1;
            r_rptCnt    <= '0;
            r_repeating <= 1'b1;
          end else if (RPT_EN && (r_rptCnt != R_MAXV)) begin
            r_rptCnt <= r_rptCnt + R_W'(1);
          end
        end

        RELEASE_CHK: begin
          if (r_pbSync) begin
            r_state     <= HELD;
            r_rptCnt    <= '0;
            r_repeating <= 1'b0;
          end else if (r_dbCnt == DB_LAST) begin
            r_state <= IDLE;
            r_level <= 1'b0;
          end else if (r_dbCnt != DB_MAX) begin
            r_dbCnt <= r_dbCnt + DB_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign PB_pulse = r_pulse;
  assign PB_level = r_level;

endmodule

// File: tb/tb_pb_debounce_pulse.sv
// tb_pb_debounce_pulse
// Drives directed and random button activity into two instances (with and
// without auto-repeat) and compares them against a run-length model of the
// debouncer, plus a 4-bit counter enabled by the non-repeating strobe.
module tb_pb_debounce_pulse;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic PB_raw = 1'b0;
  logic pulseA, levelA, pulseB, levelB;
  logic [3:0] enCount;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pq[$];
  int levelRiseCyc, levelFallCyc;

  // Model state: synchronizer pipe, debounced level, opposing-run length, hold time.
  int mS1 = 0, mS2 = 0, mL = 0, mRun = 0, mT = 0;
  logic expPA = 1'b0, expPB = 1'b0;
  int expCnt = 0;
  logic prevLevel = 1'b0;

  always #5 clk = ~clk;

  pb_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dutA (
    .clk(clk), .reset(reset), .PB_raw(PB_raw), .PB_pulse(pulseA), .PB_level(levelA)
  );

  pb_debounce_pulse #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dutB (
    .clk(clk), .reset(reset), .PB_raw(PB_raw), .PB_pulse(pulseB), .PB_level(levelB)
  );

  // Downstream counter enabled directly by the strobe.
  always @(posedge clk) begin
    if (reset) enCount <= 4'd0;
    else if (pulseB) enCount <= enCount + 4'd1;
  end

  task automatic checkBits(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare.
  task automatic applyStimulus(input logic raw, input logic rst);
    int s;
    PB_raw = raw;
    reset  = rst;
    @(posedge clk);
    if (rst) expCnt = 0;
    else if (expPB) expCnt = (expCnt + 1) % 16;
    expPA = 1'b0;
    expPB = 1'b0;
    if (rst) begin
      mS1 = 0; mS2 = 0; mL = 0; mRun = 0; mT = 0;
    end else begin
      s   = mS2;
      mS2 = mS1;
      mS1 = raw ? 1 : 0;
      if (s != mL) begin
        mRun++;
        if (mRun == DB + 1) begin
          mL   = 1 - mL;
          mRun = 0;
          mT   = 0;
          if (mL == 1) begin
            expPA = 1'b1;
            expPB = 1'b1;
          end
        end
      end else if (mRun > 0) begin
        mRun = 0;
        mT   = 0;
      end else if (mL == 1) begin
        mT++;
        if (mT == RD || (mT > RD && ((mT - RD) % RP) == 0)) expPA = 1'b1;
      end
    end
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    checkBits("pulseA", {3'b0, pulseA}, {3'b0, expPA});
    checkBits("levelA", {3'b0, levelA}, {3'b0, (mL == 1)});
    checkBits("pulseB", {3'b0, pulseB}, {3'b0, expPB});
    checkBits("levelB", {3'b0, levelB}, {3'b0, (mL == 1)});
    checkBits("count", enCount, 4'(expCnt));
    if (pulseA) pq.push_back(cyc);
    if (levelA && !prevLevel) levelRiseCyc = cyc;
    if (!levelA && prevLevel) levelFallCyc = cyc;
    prevLevel = levelA;
  endtask

  task automatic startSection();
    cyc = 0;
    pq.delete();
    levelRiseCyc = -1;
    levelFallCyc = -1;
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) applyStimulus(raw, 1'b0);
  endtask

  initial begin
    // Reset state and idle
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    hold(1'b0, 3);

    // Steady press with auto-repeat
    startSection();
    hold(1'b1, 25);
    checkInt("press_pulses", pq.size(), 4);
    if (pq.size() == 4) begin
      checkInt("press_cyc", pq[0], 7);
      checkInt("rpt1_cyc", pq[1], 17);
      checkInt("rpt2_cyc", pq[2], 20);
      checkInt("rpt3_cyc", pq[3], 23);
    end
    checkInt("level_rise", levelRiseCyc, 7);
    hold(1'b0, 12);

    // Fast toggling never gets accepted
    startSection();
    for (int i = 0; i < 20; i++) applyStimulus((i % 2) == 0, 1'b0);
    hold(1'b0, 10);
    checkInt("toggle_pulses", pq.size(), 0);
    checkInt("toggle_level", levelRiseCyc, -1);

    // Short release glitch restarts the repeat delay
    startSection();
    hold(1'b1, 12);
    hold(1'b0, 2);
    hold(1'b1, 20);
    checkInt("glitch_pulses", pq.size(), 4);
    if (pq.size() == 4) begin
      checkInt("glitch_press", pq[0], 7);
      checkInt("glitch_rpt1", pq[1], 27);
      checkInt("glitch_rpt2", pq[2], 30);
    end
    checkInt("glitch_fall", levelFallCyc, -1);
    hold(1'b0, 12);

    // Full release, then a fresh press needs the full debounce
    startSection();
    hold(1'b1, 10);
    hold(1'b0, 12);
    checkInt("release_fall", levelFallCyc, 17);
    startSection();
    hold(1'b1, 8);
    checkInt("repress_first", (pq.size() > 0) ? pq[0] : -1, 7);
    hold(1'b0, 12);

    // Reset in the middle of a press debounce
    startSection();
    hold(1'b1, 4);
    applyStimulus(1'b1, 1'b1);
    hold(1'b1, 9);
    checkInt("rst_pulses", pq.size(), 1);
    checkInt("rst_pulse_cyc", (pq.size() > 0) ? pq[0] : -1, 12);
    hold(1'b0, 12);

    // Three clean presses drive the counter to 3
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      hold(1'b1, 9);
      hold(1'b0, 12);
    end
    checkBits("count3", enCount, 4'd3);

    // Random bursts with occasional reset
    for (int b = 0; b < 80; b++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(6, 25)) : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) applyStimulus(lvl, ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
